mda_depth_filter: RTL and testbench
===================================

// Module: mda_depth_filter
// PURPOSE
//  Moving-average filter for depth-sensor ADC samples.
//  Consumes 12-bit conversions from the upstream ADC capture stage (sample_valid/sample_data, slave_clk domain).
//  Produces a boxcar-averaged depth value.
//  Exposes raw, filtered and status values through a 16-bit Avalon-MM slave for the Nios depth driver.
// PARAMETERS
//  LOG2_DEPTH  3   window = 2**LOG2_DEPTH samples (legal 1..6); sum width = 12+LOG2_DEPTH
// PORTS
//  slave_clk           in   1   sole clock
//  slave_reset_n       in   1   asynchronous, active-low reset
//  slave_chipselect_n  in   1   Avalon chipselect, active-low
//  slave_addr          in   2   register address
//  slave_read_n        in   1   Avalon read, active-low
//  slave_write_n       in   1   Avalon write, active-low
//  slave_writedata     in   16  write data
//  slave_readdata      out  16  read data, registered
//  sample_valid        in   1   1-cycle strobe: sample_data holds a new conversion
//  sample_data         in   12  unsigned ADC code
//  filt_valid          out  1   window full, filt_data meaningful
//  filt_strobe         out  1   1-cycle pulse per filt_data update
//  filt_data           out  12  window average
//  depth_irq           out  1   threshold alarm (only with MDA_DEPTH_THRESH_EN)
// BEHAVIOUR
//  Reset: all outputs 0; sum, fill count, write pointer = 0; state FILL; buffer contents don't-care.
//  State machine:
//   FILL: on sample_valid, buf[wp]<=sample; sum+=sample; wp++; cnt++.
//         Sample number 2**LOG2_DEPTH moves FILL->RUN.
//   RUN:  on sample_valid, sum <= sum + sample - buf[wp] (old entry, read before overwrite); buf[wp]<=sample; wp++.
//  wp wraps modulo 2**LOG2_DEPTH. sum never exceeds 4095*2**LOG2_DEPTH, so no saturation logic is needed.
//  Output latency: filt_data <= sum>>LOG2_DEPTH (truncating) and filt_strobe=1 two cycles after the sample_valid edge, RUN only.
//  filt_valid rises together with the first RUN filt_strobe. No strobe while in FILL.
//  Samples on back-to-back cycles are all accepted; there is no backpressure.
//  Registers (write when ~cs_n & ~write_n; read data registered 1 cycle after ~cs_n & ~read_n):
//   0 R: {13'b0, overrun, filt_valid, state==RUN}   W: bit0=1 -> clear
//   1 R: {4'b0, filt_data}
//   2 R: {4'b0, last raw sample}
//   3 R/W: {4'b0, threshold[11:0]}, reset 12'hFFF
//  overrun bit: sticky; set by sample_valid while a register-0 clear is being applied; cleared by reading reg 0.
//  clear: sum, cnt, wp, filt_valid, filt_data -> 0; state -> FILL; takes effect at the write edge.
//  Clear and sample_valid in the same cycle: clear wins, sample dropped, overrun set.
//  Clear while a strobe is in flight: the pending strobe is squashed.
//  Reads of unused bits return 0. Read and write in the same cycle: both serviced.
// CONFIGURATION
//  MDA_DEPTH_THRESH_EN defined:
//   depth_irq <= filt_valid & (filt_data > threshold), updated on each filt_strobe.
//   Once set, depth_irq holds until a write of any value to reg 3 or a clear.
//  MDA_DEPTH_THRESH_EN undefined:
//   depth_irq tied 0; reg 3 reads 0 and ignores writes.
// TESTING (LOG2_DEPTH=3)
//  Reset mid-stream (after 5 samples) -> all outputs 0; next 8 samples of 100 needed before filt_valid=1.
//  8 samples of 100 -> filt_strobe/filt_valid 2 cycles after 8th; filt_data=100; reg1=0x0064; reg0=0x0003.
//  Then 4 samples of 200 -> 4th strobe filt_data=150; 4 more -> 200. Back-to-back strobes give identical results.
//  8 samples of 4095 then 8 of 0 -> 4095, then monotonic to 0; sum never wraps.
//  Write reg0=1 coincident with sample_valid -> state FILL, filt_valid=0, reg0 reads 0x0004, then 0x0000 on the next read.
//  MDA_DEPTH_THRESH_EN: reg3=150, stream 100x8 then 200x8 -> depth_irq rises on the 5th 200-sample strobe (avg 162);
//   write reg3 -> irq drops.

Source files
------------

// File: rtl/mda_depth_filter.sv
`default_nettype none
// ============================================================================
// Module      : mda_depth_filter
// Description : Boxcar moving-average filter for 12-bit depth ADC samples with
//               a 16-bit Avalon-MM register slave. Optional threshold alarm is
//               enabled with `define MDA_DEPTH_THRESH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mda_depth_filter #(
  parameter int LOG2_DEPTH = 3
) (
  input  logic        slave_clk,
  input  logic        slave_reset_n,
  input  logic        slave_chipselect_n,
  input  logic [1:0]  slave_addr,
  input  logic        slave_read_n,
  input  logic        slave_write_n,
  input  logic [15:0] slave_writedata,
  output logic [15:0] slave_readdata,
  input  logic        sample_valid,
  input  logic [11:0] sample_data,
  output logic        filt_valid,
  output logic        filt_strobe,
  output logic [11:0] filt_data,
  output logic        depth_irq
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SW    = 12 + LOG2_DEPTH;

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]            r_state;
  logic [SW-1:0]         r_sum;
  logic [LOG2_DEPTH-1:0] r_wp;
  logic [LOG2_DEPTH-1:0] r_cnt;
  logic [11:0]           r_buf [DEPTH];
  logic                  r_pend;
  logic                  r_strobe;
  logic                  r_valid;
  logic                  r_overrun;
  logic [11:0]           r_filt;
  logic [11:0]           r_raw;
  logic [15:0]           r_rdata;

  logic                  w_wr;
  logic                  w_rd;
  logic                  w_clear;
  logic                  w_take;
  logic                  w_last_fill;
  logic [SW-1:0]         w_new;
  logic [SW-1:0]         w_old;
  logic [11:0]           w_thr;
  logic [15:0]           w_rmux;

  assign w_wr        = ~slave_chipselect_n & ~slave_write_n;
  assign w_rd        = ~slave_chipselect_n & ~slave_read_n;
  assign w_clear     = w_wr & (slave_addr == 2'd0) & slave_writedata[0];
  assign w_take      = sample_valid & ~w_clear;
  assign w_last_fill = (r_state == ST_FILL) && (r_cnt == LOG2_DEPTH'(DEPTH - 1));
  assign w_new       = SW'(sample_data);
  assign w_old       = SW'(r_buf[r_wp]);

  // Window storage carries no reset; stale entries are never summed while in FILL.
  always_ff @(posedge slave_clk) begin
    if (w_take) begin
      r_buf[r_wp] <= sample_data;
    end
  end

  always_ff @(posedge slave_clk or negedge slave_reset_n) begin
    if (!slave_reset_n) begin
      r_state  <= ST_FILL;
      r_sum    <= '0;
      r_wp     <= '0;
      r_cnt    <= '0;
      r_pend   <= 1'b0;
      r_strobe <= 1'b0;
      r_valid  <= 1'b0;
      r_filt   <= 12'h000;
    end else if (w_clear) begin
      // Clear also squashes any strobe still in the pipeline.
      r_state  <= ST_FILL;
      r_sum    <= '0;
      r_wp     <= '0;
      r_cnt    <= '0;
      r_pend   <= 1'b0;
      r_strobe <= 1'b0;
      r_valid  <= 1'b0;
      r_filt   <= 12'h000;
    end else begin
      r_strobe <= r_pend;
      r_pend   <= sample_valid & ((r_state == ST_RUN) | w_last_fill);
      if (r_pend) begin
        r_filt  <= r_sum[SW-1:LOG2_DEPTH];
        r_valid <= 1'b1;
      end
      if (sample_valid) begin
        r_wp <= r_wp + LOG2_DEPTH'(1);
        if (r_state == ST_FILL) begin
          r_sum <= r_sum + w_new;
          r_cnt <= r_cnt + LOG2_DEPTH'(1);
          if (w_last_fill) begin
            r_state <= ST_RUN;
          end
        end else begin
          r_sum <= r_sum + w_new - w_old;
        end
      end
    end
  end

  always_comb begin
    w_rmux = 16'h0000;
    case (slave_addr)
      2'd0:    w_rmux = {13'b0, r_overrun, r_valid, r_state == ST_RUN};
      2'd1:    w_rmux = {4'b0, r_filt};
      2'd2:    w_rmux = {4'b0, r_raw};
      default: w_rmux = {4'b0, w_thr};
    endcase
  end

  always_ff @(posedge slave_clk or negedge slave_reset_n) begin
    if (!slave_reset_n) begin
      r_overrun <= 1'b0;
      r_raw     <= 12'h000;
      r_rdata   <= 16'h0000;
    end else begin
      if (sample_valid) begin
        r_raw <= sample_data;
      end
      // A sample lost to a clear outranks the read-to-clear of the same cycle.
      if (sample_valid & w_clear) begin
        r_overrun <= 1'b1;
      end else if (w_rd && (slave_addr == 2'd0)) begin
        r_overrun <= 1'b0;
      end
      if (w_rd) begin
        r_rdata <= w_rmux;
      end
    end
  end

`ifdef MDA_DEPTH_THRESH_EN
  logic [11:0] r_thresh;
  logic        r_irq;
  logic        w_thr_wr;
  logic        w_unused_wdata;

  assign w_thr_wr       = w_wr & (slave_addr == 2'd3);
  assign w_unused_wdata = ^slave_writedata[15:12];

  always_ff @(posedge slave_clk or negedge slave_reset_n) begin
    if (!slave_reset_n) begin
      r_thresh <= 12'hFFF;
      r_irq    <= 1'b0;
    end else begin
      if (w_thr_wr) begin
        r_thresh <= slave_writedata[11:0];
      end
      if (w_clear | w_thr_wr) begin
        r_irq <= 1'b0;
      end else if (r_strobe & r_valid & (r_filt > r_thresh)) begin
        r_irq <= 1'b1;
      end
    end
  end

  assign w_thr     = r_thresh;
  assign depth_irq = r_irq;
`else
  logic w_unused_wdata;

  assign w_unused_wdata = ^slave_writedata[15:1];
  assign w_thr          = 12'h000;
  assign depth_irq      = 1'b0;
`endif

  assign slave_readdata = r_rdata;
  assign filt_valid     = r_valid;
  assign filt_strobe    = r_strobe;
  assign filt_data      = r_filt;

endmodule
`default_nettype wire

// File: tb/tb_mda_depth_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mda_depth_filter
// Description : Directed self-checking bench for mda_depth_filter (LOG2_DEPTH=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mda_depth_filter;

`ifdef MDA_DEPTH_THRESH_EN
  localparam bit THR = 1'b1;
`else
  localparam bit THR = 1'b0;
`endif

  logic        slave_clk = 1'b0;
  logic        slave_reset_n = 1'b0;
  logic        slave_chipselect_n = 1'b1;
  logic [1:0]  slave_addr = 2'd0;
  logic        slave_read_n = 1'b1;
  logic        slave_write_n = 1'b1;
  logic [15:0] slave_writedata = 16'h0000;
  logic [15:0] slave_readdata;
  logic        sample_valid = 1'b0;
  logic [11:0] sample_data = 12'h000;
  logic        filt_valid;
  logic        filt_strobe;
  logic [11:0] filt_data;
  logic        depth_irq;

  int n_checks = 0;
  int n_errors = 0;

  mda_depth_filter #(.LOG2_DEPTH(3)) dut (
    .slave_clk          (slave_clk),
    .slave_reset_n      (slave_reset_n),
    .slave_chipselect_n (slave_chipselect_n),
    .slave_addr         (slave_addr),
    .slave_read_n       (slave_read_n),
    .slave_write_n      (slave_write_n),
    .slave_writedata    (slave_writedata),
    .slave_readdata     (slave_readdata),
    .sample_valid       (sample_valid),
    .sample_data        (sample_data),
    .filt_valid         (filt_valid),
    .filt_strobe        (filt_strobe),
    .filt_data          (filt_data),
    .depth_irq          (depth_irq)
  );

  always #5 slave_clk = ~slave_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge slave_clk);
    #1;
  endtask

  task automatic send(input logic [11:0] v);
    sample_valid = 1'b1;
    sample_data  = v;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic reg_wr(input logic [1:0] a, input logic [15:0] d);
    slave_chipselect_n = 1'b0;
    slave_write_n      = 1'b0;
    slave_addr         = a;
    slave_writedata    = d;
    tick();
    slave_chipselect_n = 1'b1;
    slave_write_n      = 1'b1;
  endtask

  task automatic reg_rd(input string tag, input logic [1:0] a, input logic [15:0] exp);
    slave_chipselect_n = 1'b0;
    slave_read_n       = 1'b0;
    slave_addr         = a;
    tick();
    slave_chipselect_n = 1'b1;
    slave_read_n       = 1'b1;
    check(tag, {16'h0, slave_readdata}, {16'h0, exp});
  endtask

  task automatic chk_out(input string tag, input logic s, input logic v, input logic [11:0] d);
    check({tag, "_strobe"}, {31'h0, filt_strobe}, {31'h0, s});
    check({tag, "_valid"},  {31'h0, filt_valid},  {31'h0, v});
    check({tag, "_data"},   {20'h0, filt_data},   {20'h0, d});
  endtask

  logic [11:0] step_exp [8] = '{12'd112, 12'd125, 12'd137, 12'd150,
                                12'd162, 12'd175, 12'd187, 12'd200};
  logic [11:0] b2b_exp [16] = '{12'd686,  12'd1173, 12'd1660, 12'd2147,
                                12'd2634, 12'd3121, 12'd3608, 12'd4095,
                                12'd3583, 12'd3071, 12'd2559, 12'd2047,
                                12'd1535, 12'd1023, 12'd511,  12'd0};

  initial begin
    tick();
    tick();
    chk_out("rst", 1'b0, 1'b0, 12'd0);
    check("rst_irq", {31'h0, depth_irq}, 32'h0);
    check("rst_rdata", {16'h0, slave_readdata}, 32'h0);
    slave_reset_n = 1'b1;
    tick();
    reg_rd("rst_reg0", 2'd0, 16'h0000);
    reg_rd("rst_reg3", 2'd3, THR ? 16'h0FFF : 16'h0000);

    // Partial fill, then asynchronous reset mid-stream.
    for (int i = 0; i < 5; i++) send(12'd100);
    #2 slave_reset_n = 1'b0;
    #2;
    chk_out("midrst", 1'b0, 1'b0, 12'd0);
    tick();
    slave_reset_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) send(12'd100);
    tick();
    tick();
    chk_out("fill7", 1'b0, 1'b0, 12'd0);
    send(12'd100);
    check("fill8_pend_valid", {31'h0, filt_valid}, 32'h0);
    tick();
    chk_out("fill8", 1'b1, 1'b1, 12'd100);
    tick();
    check("fill8_strobe_off", {31'h0, filt_strobe}, 32'h0);
    reg_rd("reg1_100", 2'd1, 16'h0064);
    reg_rd("reg0_run", 2'd0, 16'h0003);
    reg_rd("reg2_raw", 2'd2, 16'h0064);

    reg_wr(2'd3, 16'd150);
    reg_rd("reg3_150", 2'd3, THR ? 16'd150 : 16'h0000);

    // Step from 100 to 200, one sample at a time.
    for (int k = 0; k < 8; k++) begin
      send(12'd200);
      tick();
      chk_out($sformatf("step%0d", k + 1), 1'b1, 1'b1, step_exp[k]);
      tick();
      check($sformatf("step%0d_irq", k + 1), {31'h0, depth_irq}, {31'h0, THR && (k >= 4)});
    end
    reg_wr(2'd3, 16'h0FFF);
    check("irq_drop", {31'h0, depth_irq}, 32'h0);
    reg_rd("reg3_fff", 2'd3, THR ? 16'h0FFF : 16'h0000);

    // Back-to-back full-scale then zero samples.
    for (int t = 0; t <= 16; t++) begin
      sample_valid = (t < 16);
      sample_data  = (t < 8) ? 12'd4095 : 12'd0;
      tick();
      if (t >= 1) chk_out($sformatf("b2b%0d", t - 1), 1'b1, 1'b1, b2b_exp[t - 1]);
    end
    sample_valid = 1'b0;
    tick();
    check("b2b_strobe_off", {31'h0, filt_strobe}, 32'h0);
    check("b2b_irq", {31'h0, depth_irq}, 32'h0);

    // Clear in the cycle a strobe would land: strobe is squashed.
    send(12'd50);
    reg_wr(2'd0, 16'h0001);
    chk_out("squash", 1'b0, 1'b0, 12'd0);
    tick();
    check("squash_late", {31'h0, filt_strobe}, 32'h0);
    reg_rd("squash_reg0", 2'd0, 16'h0000);

    // Clear coincident with a sample: sample dropped, overrun set.
    send(12'd10);
    send(12'd10);
    slave_chipselect_n = 1'b0;
    slave_write_n      = 1'b0;
    slave_addr         = 2'd0;
    slave_writedata    = 16'h0001;
    sample_valid       = 1'b1;
    sample_data        = 12'd77;
    tick();
    slave_chipselect_n = 1'b1;
    slave_write_n      = 1'b1;
    sample_valid       = 1'b0;
    chk_out("clr_coinc", 1'b0, 1'b0, 12'd0);
    reg_rd("ovr_set", 2'd0, 16'h0004);
    reg_rd("ovr_clr", 2'd0, 16'h0000);

    // After clear a full window is needed again.
    for (int i = 0; i < 7; i++) send(12'd10);
    tick();
    check("refill7_valid", {31'h0, filt_valid}, 32'h0);
    send(12'd10);
    tick();
    chk_out("refill8", 1'b1, 1'b1, 12'd10);
    reg_rd("refill_reg0", 2'd0, 16'h0003);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
